hex_keypad_emulator: RTL and testbench
======================================

// Module: hex_keypad_emulator
// PURPOSE
//   Behavioural-synthesisable model of a 4x4 hex keypad, the responder to the keypad scanner.
//   On a press request it closes the switch at (row,col) = (key_code[3:2], key_code[1:0]),
//   with contact bounce on press and release. While closed it returns the scanner's column
//   drive on the matching row line. Used in FPGA self-test and bench loopback with the scanner.
// PARAMETERS
//   BOUNCE_CYCLES  8   cycles of contact bounce on press and on release; 0 = no bounce phases
//   BOUNCE_PERIOD  2   contact toggles every BOUNCE_PERIOD cycles during bounce; >=1
//   HOLD_CYCLES    64  cycles of stable closure; >=1
//   CNT_W          16  phase counter width; all cycle parameters < 2**CNT_W
// PORTS
//   clock     in   1  rising-edge clock
//   reset     in   1  asynchronous, active-high reset
//   press_req in   1  request a key press; sampled only in IDLE
//   key_code  in   4  key to press, latched with press_req; code = 4*row + col
//   Col       in   4  column drive from the scanner, one-hot or 4'b1111
//   Row       out  4  row sense returned to the scanner
//   S_Row     out  1  registered key-detect, equal to |Row delayed one cycle
//   busy      out  1  high while a press/release sequence is in progress
//   done      out  1  one-cycle pulse when the sequence completes
// BEHAVIOUR
//   Reset (async): state=IDLE, cnt=0, key=0. Row, S_Row, busy and done are all 0 immediately.
//   FSM states, one cnt increment per cycle; cnt clears on every state change:
//     IDLE: if press_req, latch key<=key_code. Next state is BOUNCE_IN, or HELD if BOUNCE_CYCLES==0.
//     BOUNCE_IN: at cnt==BOUNCE_CYCLES-1, go to HELD.
//     HELD: at cnt==HOLD_CYCLES-1, go to BOUNCE_OUT, or IDLE if BOUNCE_CYCLES==0.
//     BOUNCE_OUT: at cnt==BOUNCE_CYCLES-1, go to IDLE.
//   contact (combinational from state, cnt):
//     HELD: 1. IDLE: 0.
//     BOUNCE_IN: ((cnt/BOUNCE_PERIOD)%2==0), so the first cycle is closed.
//     BOUNCE_OUT: ((cnt/BOUNCE_PERIOD)%2==1), so the first cycle is open.
//   Row output:
//     Row is purely combinational from contact, key and Col, with zero cycle latency.
//     Row[r] = contact & (r==key[3:2]) & Col[key[1:0]]. At most one Row bit is high.
//     Col=4'b1111 returns the key's row bit whenever contact=1.
//   S_Row <= |Row on each clock edge.
//   busy = (state != IDLE).
//   done: registered. It is 1 for exactly the cycle after the transition into IDLE from
//     HELD or BOUNCE_OUT. That cycle has busy=0.
//   press_req while busy is ignored; it is not queued.
//     A press_req in the done cycle is accepted.
//   key_code changes while busy have no effect.
//   Reset mid-sequence: Row drops to 0 asynchronously. No done pulse is produced.
//   Latency: press_req high at edge N makes busy=1 and contact=1 at cycle N+1.
//   Total busy duration = 2*BOUNCE_CYCLES + HOLD_CYCLES cycles.
// TESTING
//   1. Defaults; key_code=9, press_req at edge 0, Col=4'b0010.
//      -> busy 1..80. Row=4'b0100 in cycles 1-2, 0 in 3-4, ..., steady 9..72.
//      -> Row toggles open-first in 73..80. done=1 only in cycle 81.
//   2. Key 9 HELD, sweep Col 0001/0010/0100/1000/1111.
//      -> Row=0000/0100/0000/0000/0100, combinational in the same cycle.
//      -> S_Row follows one cycle later.
//   3. All codes 0..15, BOUNCE_CYCLES=0, Col=4'b1111 during HELD.
//      -> Row=1<<(code>>2). busy lasts exactly HOLD_CYCLES cycles.
//   4. press_req pulsed at cycle 30 of a sequence with key_code=5.
//      -> ignored; Row still reflects the latched key; done count stays 1.
//   5. reset asserted in cycle 40 (HELD).
//      -> Row=0, busy=0, S_Row=0 immediately. No done pulse. Next press_req accepted.
//   6. Loopback with the scanner, keys 0x0, 0x7, 0xA, 0xF.
//      -> the scanner reports a valid Code equal to key_code during HELD.
//      -> the scanner's valid flag drops after BOUNCE_OUT.

Source files
------------

// File: rtl/hex_keypad_emulator.sv
// 4x4 hex keypad responder for a keypad scanner: closes one switch with contact
// bounce on press and release, and returns the scanner's column drive on the key's row.
module hex_keypad_emulator #(
  parameter int BOUNCE_CYCLES = 8,
  parameter int BOUNCE_PERIOD = 2,
  parameter int HOLD_CYCLES   = 64,
  parameter int CNT_W         = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       press_req,
  input  logic [3:0] key_code,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       S_Row,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] BOUNCE_IN  = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] BOUNCE_OUT = 2'd3;

  localparam bit NO_BOUNCE = (BOUNCE_CYCLES == 0);
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'((BOUNCE_PERIOD > 0) ? BOUNCE_PERIOD - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_q, key_d;
  // per_q/ph_q track (cnt / BOUNCE_PERIOD) % 2 without a divider.
  logic [CNT_W-1:0] per_q, per_d;
  logic             ph_q, ph_d;
  logic             s_row_q, s_row_d;
  logic             done_q, done_d;
  logic             contact;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    key_d   = key_q;
    per_d   = per_q;
    ph_d    = ph_q;

    case (state_q)
      IDLE: begin
        if (press_req) begin
          key_d   = key_code;
          state_d = NO_BOUNCE ? HELD : BOUNCE_IN;
        end
      end
      BOUNCE_IN: begin
        if (cnt_q == BOUNCE_LAST) state_d = HELD;
      end
      HELD: begin
        if (cnt_q == HOLD_LAST) state_d = NO_BOUNCE ? IDLE : BOUNCE_OUT;
      end
      BOUNCE_OUT: begin
        if (cnt_q == BOUNCE_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (per_q == PERIOD_LAST) begin
      per_d = '0;
      ph_d  = ~ph_q;
    end else begin
      per_d = per_q + CNT_W'(1);
    end

    if ((state_d != state_q) || (state_q == IDLE)) begin
      cnt_d = '0;
      per_d = '0;
      ph_d  = 1'b0;
    end

    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  always_comb begin
    case (state_q)
      HELD:       contact = 1'b1;
      BOUNCE_IN:  contact = ~ph_q;
      BOUNCE_OUT: contact = ph_q;
      default:    contact = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign Row[gi] = contact & (key_q[3:2] == 2'(gi)) & Col[key_q[1:0]];
  end

  assign s_row_d = |Row;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      per_q   <= '0;
      ph_q    <= 1'b0;
      s_row_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      per_q   <= per_d;
      ph_q    <= ph_d;
      s_row_q <= s_row_d;
      done_q  <= done_d;
    end
  end

  assign S_Row = s_row_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_hex_keypad_emulator.sv
// Directed bench for hex_keypad_emulator: default instance plus a no-bounce instance.
module tb_hex_keypad_emulator;

  logic       clk;
  logic       reset;
  logic       press_req, press0;
  logic [3:0] key_code, key0;
  logic [3:0] Col, col0;
  logic [3:0] Row, row0;
  logic       S_Row, s_row0;
  logic       busy, busy0;
  logic       done, done0;

  int n_chk  = 0;
  int n_pass = 0;

  hex_keypad_emulator dut (
    .clock(clk), .reset(reset), .press_req(press_req), .key_code(key_code),
    .Col(Col), .Row(Row), .S_Row(S_Row), .busy(busy), .done(done)
  );

  hex_keypad_emulator #(.BOUNCE_CYCLES(0), .HOLD_CYCLES(4)) dut0 (
    .clock(clk), .reset(reset), .press_req(press0), .key_code(key0),
    .Col(col0), .Row(row0), .S_Row(s_row0), .busy(busy0), .done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] col;
    logic [3:0] row;
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  // Expected contact for the default parameters, cycle 1 = first busy cycle.
  function automatic logic exp_contact(input int c);
    if (c >= 1 && c <= 8)   return ((c - 1) / 2) % 2 == 0;
    if (c >= 9 && c <= 72)  return 1'b1;
    if (c >= 73 && c <= 80) return ((c - 73) / 2) % 2 == 1;
    return 1'b0;
  endfunction

  task automatic start_press(input logic [3:0] k, input logic [3:0] col);
    @(negedge clk);
    key_code  = k;
    Col       = col;
    press_req = 1'b1;
    @(negedge clk);
    press_req = 1'b0;
  endtask

  task automatic run_cycles(input int n, output int dones);
    dones = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) dones++;
    end
  endtask

  task automatic scan(output int found, output logic [3:0] code);
    found = 0;
    code  = 4'h0;
    for (int c = 0; c < 4; c++) begin
      Col = 4'b0001 << c;
      #1;
      for (int r = 0; r < 4; r++) begin
        if (Row[r]) begin
          found++;
          code = 4'(4 * r + c);
        end
      end
    end
    Col = 4'b1111;
  endtask

  initial begin
    vec_t       tbl[5];
    logic [3:0] keys[4];
    logic [3:0] exp_row, code;
    logic       prev_s;
    int         dones, found, nbusy;

    tbl[0] = '{4'b0001, 4'b0000};
    tbl[1] = '{4'b0010, 4'b0100};
    tbl[2] = '{4'b0100, 4'b0000};
    tbl[3] = '{4'b1000, 4'b0000};
    tbl[4] = '{4'b1111, 4'b0100};
    keys[0] = 4'h0; keys[1] = 4'h7; keys[2] = 4'hA; keys[3] = 4'hF;

    reset = 1'b1; press_req = 1'b0; key_code = 4'h0; Col = 4'b1111;
    press0 = 1'b0; key0 = 4'h0; col0 = 4'b1111;
    #2;
    chk("rst_row", 8'(Row), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_srow", 8'(S_Row), 8'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Full sequence, key 9 on Col 0010.
    start_press(4'd9, 4'b0010);
    prev_s = 1'b0;
    for (int c = 1; c <= 81; c++) begin
      exp_row = exp_contact(c) ? 4'b0100 : 4'b0000;
      chk($sformatf("t1_row c%0d", c), 8'(Row), 8'(exp_row));
      chk($sformatf("t1_busy c%0d", c), 8'(busy), 8'(c <= 80));
      chk($sformatf("t1_done c%0d", c), 8'(done), 8'(c == 81));
      chk($sformatf("t1_srow c%0d", c), 8'(S_Row), 8'(prev_s));
      prev_s = |exp_row;
      @(negedge clk);
    end

    // Column sweep while held.
    start_press(4'd9, 4'b1111);
    repeat (19) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      Col = tbl[i].col;
      #1;
      chk($sformatf("t2_row col=%b", tbl[i].col), 8'(Row), 8'(tbl[i].row));
      @(negedge clk);
      chk($sformatf("t2_srow col=%b", tbl[i].col), 8'(S_Row), 8'(|tbl[i].row));
    end
    Col = 4'b1111;
    run_cycles(60, dones);
    chk("t2_dones", 8'(dones), 8'd1);
    chk("t2_idle", 8'(busy), 8'h0);

    // No-bounce instance, all codes.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      key0 = 4'(k); col0 = 4'b1111; press0 = 1'b1;
      @(negedge clk);
      press0 = 1'b0;
      nbusy = 0;
      dones = 0;
      exp_row = 4'b0001 << key0[3:2];
      for (int i = 0; i < 10; i++) begin
        if (busy0) begin
          nbusy++;
          chk($sformatf("t3_row k%0d", k), 8'(row0), 8'(exp_row));
        end
        if (done0) dones++;
        @(negedge clk);
      end
      chk($sformatf("t3_busylen k%0d", k), 8'(nbusy), 8'd4);
      chk($sformatf("t3_done k%0d", k), 8'(dones), 8'd1);
    end

    // press_req while busy is ignored.
    start_press(4'd9, 4'b1111);
    repeat (29) @(negedge clk);
    key_code = 4'd5; press_req = 1'b1;
    @(negedge clk);
    press_req = 1'b0;
    chk("t4_row", 8'(Row), 8'h04);
    chk("t4_busy", 8'(busy), 8'h1);
    run_cycles(55, dones);
    chk("t4_dones", 8'(dones), 8'd1);
    chk("t4_idle", 8'(busy), 8'h0);

    // Reset mid-hold.
    start_press(4'd9, 4'b1111);
    repeat (39) @(negedge clk);
    chk("t5_row_pre", 8'(Row), 8'h04);
    #1 reset = 1'b1;
    #1;
    chk("t5_row", 8'(Row), 8'h0);
    chk("t5_busy", 8'(busy), 8'h0);
    chk("t5_srow", 8'(S_Row), 8'h0);
    chk("t5_done", 8'(done), 8'h0);
    @(negedge clk);
    reset = 1'b0;
    run_cycles(90, dones);
    chk("t5_nodone", 8'(dones), 8'd0);
    start_press(4'd3, 4'b1111);
    chk("t5_rebusy", 8'(busy), 8'h1);
    chk("t5_rerow", 8'(Row), 8'h01);
    run_cycles(85, dones);
    chk("t5_redone", 8'(dones), 8'd1);

    // Loopback scan during HELD and after release.
    for (int i = 0; i < 4; i++) begin
      start_press(keys[i], 4'b1111);
      repeat (19) @(negedge clk);
      scan(found, code);
      chk($sformatf("t6_valid k%0h", keys[i]), 8'(found), 8'd1);
      chk($sformatf("t6_code k%0h", keys[i]), 8'(code), 8'(keys[i]));
      run_cycles(65, dones);
      chk($sformatf("t6_done k%0h", keys[i]), 8'(dones), 8'd1);
      scan(found, code);
      chk($sformatf("t6_novalid k%0h", keys[i]), 8'(found), 8'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
